// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and standard/FWFT read.
// Sticky Overflow/Underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned AF_LEVEL   = 28,
  parameter int unsigned AE_LEVEL   = 4,
  parameter int unsigned FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] DataIn,
  input  logic                  Wr_enable,
  input  logic                  Read_enable,
  input  logic                  Err_clear,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Empty,
  output logic                  Full,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Overflow,
  output logic                  Underflow
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DepthCnt = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AfCnt    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AeCnt    = (ADDR_WIDTH + 1)'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_acc, rd_acc;

  assign Empty       = (count_q == '0);
  assign Full        = (count_q == DepthCnt);
  assign AlmostFull  = (count_q >= AfCnt);
  assign AlmostEmpty = (count_q <= AeCnt);
  assign Count       = count_q;

  assign wr_acc = Wr_enable && !Full;
  assign rd_acc = Read_enable && !Empty;

  always_comb begin
    w_addr_d = wr_acc ? w_addr_q + 1'b1 : w_addr_q;
    r_addr_d = rd_acc ? r_addr_q + 1'b1 : r_addr_q;
    count_d  = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_addr_q <= '0;
      r_addr_q <= '0;
      count_q  <= '0;
    end else begin
      w_addr_q <= w_addr_d;
      r_addr_q <= r_addr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[w_addr_q] <= DataIn;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign DataOut = Empty ? '0 : mem_q[r_addr_q];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_q[r_addr_q];
      end
    end
    assign DataOut = dout_q;
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;
  // A new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (Wr_enable && Full) begin
        ovf_q <= 1'b1;
      end else if (Err_clear) begin
        ovf_q <= 1'b0;
      end
      if (Read_enable && Empty) begin
        unf_q <= 1'b1;
      end else if (Err_clear) begin
        unf_q <= 1'b0;
      end
    end
  end
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = Err_clear;
  assign Overflow  = 1'b0;
  assign Underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench: standard and FWFT instances driven together, checked against a queue model.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 32;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] DataIn = '0;
  logic       Wr_enable = 1'b0, Read_enable = 1'b0, Err_clear = 1'b0;

  logic [7:0] dout_s, dout_f;
  logic       empty_s, full_s, af_s, ae_s, ovf_s, unf_s;
  logic       empty_f, full_f, af_f, ae_f, ovf_f, unf_f;
  logic [5:0] cnt_s, cnt_f;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] q[$];
  logic [7:0] m_dout = '0;
  bit         m_ovf = 0, m_unf = 0;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .DataIn(DataIn), .Wr_enable(Wr_enable),
    .Read_enable(Read_enable), .Err_clear(Err_clear), .DataOut(dout_s),
    .Empty(empty_s), .Full(full_s), .AlmostFull(af_s), .AlmostEmpty(ae_s),
    .Count(cnt_s), .Overflow(ovf_s), .Underflow(unf_s)
  );

  sync_fifo_ctrl #(.FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .DataIn(DataIn), .Wr_enable(Wr_enable),
    .Read_enable(Read_enable), .Err_clear(Err_clear), .DataOut(dout_f),
    .Empty(empty_f), .Full(full_f), .AlmostFull(af_f), .AlmostEmpty(ae_f),
    .Count(cnt_f), .Overflow(ovf_f), .Underflow(unf_f)
  );

  function automatic logic [5:0] exp_flags();
    int n = q.size();
    return {n == 0, n == DEPTH, n >= 28, n <= 4, ErrEn && m_ovf, ErrEn && m_unf};
  endfunction

  function automatic logic [7:0] exp_fwft();
    return (q.size() > 0) ? q[0] : 8'h00;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 0;
    m_unf  = 0;
  endfunction

  // Drive one cycle of requests, advance through the edge, update the model.
  task automatic cycle(input bit wr, input bit rd, input logic [7:0] din, input bit clr);
    bit full_now, empty_now;
    Wr_enable   = wr;
    Read_enable = rd;
    DataIn      = din;
    Err_clear   = clr;
    @(posedge clk);
    full_now  = (q.size() == DEPTH);
    empty_now = (q.size() == 0);
    m_ovf = (wr && full_now) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (rd && empty_now) ? 1'b1 : (clr ? 1'b0 : m_unf);
    if (rd && !empty_now) m_dout = q.pop_front();
    if (wr && !full_now) q.push_back(din);
    #1;
    Wr_enable   = 1'b0;
    Read_enable = 1'b0;
    Err_clear   = 1'b0;
  endtask

  task automatic test_reset();
    #12 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({empty_s, full_s, af_s, ae_s, ovf_s, unf_s, cnt_s, dout_s} !== {6'b100100, 6'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_init: got flags=%b cnt=%0d dout=%h expected flags=100100 cnt=0 dout=00",
               {empty_s, full_s, af_s, ae_s, ovf_s, unf_s}, cnt_s, dout_s);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, (i == 4), 8'(8'h30 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'h77, 1'b0);
    Wr_enable = 1'b1;
    #2 rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({empty_s, full_s, ae_s, ovf_s, cnt_s, dout_s, empty_f, cnt_f, dout_f} !==
        {4'b1010, 6'd0, 8'h00, 1'b1, 6'd0, 8'h00}) begin
      errors++;
      $display("FAIL reset_async: got E=%b F=%b AE=%b OV=%b cnt=%0d dout=%h fcnt=%0d fdout=%h expected 1 0 1 0 0 00 0 00",
               empty_s, full_s, ae_s, ovf_s, cnt_s, dout_s, cnt_f, dout_f);
    end
    Wr_enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, 8'(i), 1'b0);
      checks++;
      if ({empty_s, full_s, af_s, ae_s, ovf_s, unf_s} !== exp_flags() || cnt_s !== 6'(i + 1)) begin
        errors++;
        $display("FAIL fill_%0d: got flags=%b cnt=%0d expected flags=%b cnt=%0d",
                 i + 1, {empty_s, full_s, af_s, ae_s, ovf_s, unf_s}, cnt_s, exp_flags(), i + 1);
      end
    end
    cycle(1'b1, 1'b0, 8'hAA, 1'b0);
    checks++;
    if (cnt_s !== 6'd32 || full_s !== 1'b1 || ovf_s !== ErrEn) begin
      errors++;
      $display("FAIL fill_overflow: got cnt=%0d full=%b ovf=%b expected cnt=32 full=1 ovf=%b",
               cnt_s, full_s, ovf_s, ErrEn);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (dout_s !== 8'(i) || cnt_s !== 6'(DEPTH - 1 - i) || dout_f !== exp_fwft()) begin
        errors++;
        $display("FAIL drain_%0d: got dout=%h cnt=%0d fdout=%h expected dout=%h cnt=%0d fdout=%h",
                 i, dout_s, cnt_s, dout_f, 8'(i), DEPTH - 1 - i, exp_fwft());
      end
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (empty_s !== 1'b1 || unf_s !== ErrEn || ovf_s !== ErrEn || dout_s !== 8'h1F || dout_f !== 8'h00) begin
      errors++;
      $display("FAIL drain_underflow: got E=%b unf=%b ovf=%b dout=%h fdout=%h expected 1 %b %b 1f 00",
               empty_s, unf_s, ovf_s, dout_s, dout_f, ErrEn, ErrEn);
    end
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (ovf_s !== 1'b0 || unf_s !== 1'b0 || ovf_f !== 1'b0 || unf_f !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got ovf=%b unf=%b fovf=%b funf=%b expected all 0",
               ovf_s, unf_s, ovf_f, unf_f);
    end
  endtask

  task automatic test_wrap();
    int k = 0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 8'(8'h80 + r * 20 + i), 1'b0);
      for (int i = 0; i < 20; i++) begin
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        checks++;
        if (dout_s !== 8'(8'h80 + k) || {empty_s, full_s, af_s, ae_s, ovf_s, unf_s} !== exp_flags()) begin
          errors++;
          $display("FAIL wrap_%0d: got dout=%h flags=%b expected dout=%h flags=%b",
                   k, dout_s, {empty_s, full_s, af_s, ae_s, ovf_s, unf_s}, 8'(8'h80 + k), exp_flags());
        end
        k++;
      end
    end
    checks++;
    if (cnt_s !== 6'd0 || ovf_s !== 1'b0 || unf_s !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end: got cnt=%0d ovf=%b unf=%b expected 0 0 0", cnt_s, ovf_s, unf_s);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'h15, 1'b0);
    checks++;
    if (cnt_s !== 6'd5 || dout_s !== 8'h10 || dout_f !== 8'h11) begin
      errors++;
      $display("FAIL simul_mid: got cnt=%0d dout=%h fdout=%h expected 5 10 11", cnt_s, dout_s, dout_f);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 8'h00, 1'b0);
      checks++;
      if (dout_s !== 8'(8'h11 + i)) begin
        errors++;
        $display("FAIL simul_order_%0d: got %h expected %h", i, dout_s, 8'(8'h11 + i));
      end
    end
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0);
    cycle(1'b1, 1'b1, 8'hEE, 1'b0);
    checks++;
    if (cnt_s !== 6'd31 || ovf_s !== ErrEn || dout_s !== 8'hC0) begin
      errors++;
      $display("FAIL simul_full: got cnt=%0d ovf=%b dout=%h expected 31 %b c0", cnt_s, ovf_s, dout_s, ErrEn);
    end
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    cycle(1'b1, 1'b1, 8'h3C, 1'b0);
    checks++;
    if (cnt_s !== 6'd1 || unf_s !== ErrEn || ovf_s !== 1'b0 || dout_f !== 8'h3C) begin
      errors++;
      $display("FAIL simul_empty: got cnt=%0d unf=%b ovf=%b fdout=%h expected 1 %b 0 3c",
               cnt_s, unf_s, ovf_s, dout_f, ErrEn);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b1);
  endtask

  task automatic test_fwft();
    cycle(1'b1, 1'b0, 8'h5A, 1'b0);
    checks++;
    if (empty_f !== 1'b0 || dout_f !== 8'h5A) begin
      errors++;
      $display("FAIL fwft_show: got E=%b dout=%h expected 0 5a", empty_f, dout_f);
    end
    cycle(1'b0, 1'b1, 8'h00, 1'b0);
    checks++;
    if (empty_f !== 1'b1 || dout_f !== 8'h00 || dout_s !== 8'h5A) begin
      errors++;
      $display("FAIL fwft_pop: got E=%b fdout=%h sdout=%h expected 1 00 5a", empty_f, dout_f, dout_s);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      // Bias toward writes in the first half so the full region is reached.
      bit wr = ($urandom_range(99) < ((n < 1500) ? 65 : 40));
      bit rd = ($urandom_range(99) < ((n < 1500) ? 40 : 65));
      bit clr = ($urandom_range(99) < 5);
      cycle(wr, rd, 8'($urandom), clr);
      checks++;
      if ({empty_s, full_s, af_s, ae_s, ovf_s, unf_s} !== exp_flags() ||
          {empty_f, full_f, af_f, ae_f, ovf_f, unf_f} !== exp_flags() ||
          cnt_s !== 6'(q.size()) || cnt_f !== 6'(q.size()) ||
          dout_s !== m_dout || dout_f !== exp_fwft()) begin
        errors++;
        $display("FAIL random_%0d: got flags=%b/%b cnt=%0d/%0d dout=%h fdout=%h expected flags=%b cnt=%0d dout=%h fdout=%h",
                 n, {empty_s, full_s, af_s, ae_s, ovf_s, unf_s}, {empty_f, full_f, af_f, ae_f, ovf_f, unf_f},
                 cnt_s, cnt_f, dout_s, dout_f, exp_flags(), q.size(), m_dout, exp_fwft());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_fwft();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
